// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle RV32I datapath: fetch/decode/execute/memory/writeback
// sequencing with a memory-ready handshake, beq/bne and an illegal-opcode trap.
module multicycle_control_unit #(
   parameter int unsigned INSTR_WIDTH = 32,
   parameter bit          MEM_WAIT_EN = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   input  logic                   eq_i,
   input  logic                   mem_ready_i,
   output logic                   PCWrite_o,
   output logic                   AdrSrc_o,
   output logic                   MemWrite_o,
   output logic                   IRWrite_o,
   output logic [1:0]             ResultSrc_o,
   output logic [1:0]             ALUSrcA_o,
   output logic [1:0]             ALUSrcB_o,
   output logic [2:0]             ALUControl_o,
   output logic [1:0]             ImmSrc_o,
   output logic                   RegWrite_o,
   output logic [3:0]             state_o,
   output logic                   illegal_o
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
      StJal      = 4'd10,
      StTrap     = 4'd11
   } state_e;

   localparam logic [6:0] OpLw     = 7'b0000011;
   localparam logic [6:0] OpSw     = 7'b0100011;
   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpI      = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluSlt = 3'b101;

   state_e     state_q, state_d;
   logic [6:0] op_q;
   logic [2:0] f3_q;
   logic       f7b5_q;
   logic       ready;
   logic [6:0] op_dec;
   logic [2:0] alu_fn;
   logic       unused_instr_bits;

   assign unused_instr_bits = ^instr_i;
   assign ready = MEM_WAIT_EN ? mem_ready_i : 1'b1;
   // DECODE sees the live opcode; every later state uses the captured copy.
   assign op_dec = (state_q == StDecode) ? instr_i[6:0] : op_q;
   assign state_o = state_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StFetch;
         op_q    <= '0;
         f3_q    <= '0;
         f7b5_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StDecode) begin
            op_q   <= instr_i[6:0];
            f3_q   <= instr_i[14:12];
            f7b5_q <= instr_i[30];
         end
      end
   end

   always_comb begin
      alu_fn = AluAdd;
      case (f3_q)
         3'b000:  alu_fn = (op_q[5] & f7b5_q) ? AluSub : AluAdd;
         3'b010:  alu_fn = AluSlt;
         3'b110:  alu_fn = AluOr;
         3'b111:  alu_fn = AluAnd;
         default: alu_fn = AluAdd;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      PCWrite_o    = 1'b0;
      AdrSrc_o     = 1'b0;
      MemWrite_o   = 1'b0;
      IRWrite_o    = 1'b0;
      ResultSrc_o  = 2'b00;
      ALUSrcA_o    = 2'b00;
      ALUSrcB_o    = 2'b00;
      ALUControl_o = AluAdd;
      RegWrite_o   = 1'b0;
      illegal_o    = 1'b0;

      case (op_dec)
         OpSw:     ImmSrc_o = 2'b01;
         OpBranch: ImmSrc_o = 2'b10;
         OpJal:    ImmSrc_o = 2'b11;
         default:  ImmSrc_o = 2'b00;
      endcase

      case (state_q)
         StFetch: begin
            IRWrite_o   = ready;
            PCWrite_o   = ready;
            ALUSrcB_o   = 2'b10;
            ResultSrc_o = 2'b10;
            if (ready) state_d = StDecode;
         end
         StDecode: begin
            ALUSrcA_o = 2'b01;
            ALUSrcB_o = 2'b01;
            case (instr_i[6:0])
               OpLw, OpSw: state_d = StMemAdr;
               OpR:        state_d = StExecR;
               OpI:        state_d = StExecI;
               OpBranch:   state_d = StBranch;
               OpJal:      state_d = StJal;
               default:    state_d = StTrap;
            endcase
         end
         StMemAdr: begin
            ALUSrcA_o = 2'b10;
            ALUSrcB_o = 2'b01;
            state_d   = (op_q == OpLw) ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            AdrSrc_o = 1'b1;
            if (ready) state_d = StMemWb;
         end
         StMemWb: begin
            ResultSrc_o = 2'b01;
            RegWrite_o  = 1'b1;
            state_d     = StFetch;
         end
         StMemWrite: begin
            AdrSrc_o   = 1'b1;
            MemWrite_o = 1'b1;
            if (ready) state_d = StFetch;
         end
         StExecR: begin
            ALUSrcA_o    = 2'b10;
            ALUControl_o = alu_fn;
            state_d      = StAluWb;
         end
         StExecI: begin
            ALUSrcA_o    = 2'b10;
            ALUSrcB_o    = 2'b01;
            ALUControl_o = alu_fn;
            state_d      = StAluWb;
         end
         StAluWb: begin
            RegWrite_o = 1'b1;
            state_d    = StFetch;
         end
         StBranch: begin
            ALUSrcA_o    = 2'b10;
            ALUControl_o = AluSub;
            PCWrite_o    = ((f3_q == 3'b000) & eq_i) | ((f3_q == 3'b001) & ~eq_i);
            state_d      = StFetch;
         end
         StJal: begin
            ALUSrcA_o = 2'b01;
            ALUSrcB_o = 2'b10;
            PCWrite_o = 1'b1;
            state_d   = StAluWb;
         end
         StTrap: begin
            illegal_o = 1'b1;
         end
         default: state_d = StFetch;
      endcase

      // Reset holds FETCH values on the muxes but must not fire any write.
      if (rst_i) begin
         PCWrite_o  = 1'b0;
         IRWrite_o  = 1'b0;
         MemWrite_o = 1'b0;
         RegWrite_o = 1'b0;
         illegal_o  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; outputs sampled 1ns after negedge.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        eq = 1'b0;
   logic        mem_ready = 1'b1;
   logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0]  alu_control;
   logic [3:0]  state;
   int          checks = 0;
   int          passes = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.INSTR_WIDTH(32), .MEM_WAIT_EN(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .instr_i(instr), .eq_i(eq), .mem_ready_i(mem_ready),
      .PCWrite_o(pc_write), .AdrSrc_o(adr_src), .MemWrite_o(mem_write), .IRWrite_o(ir_write),
      .ResultSrc_o(result_src), .ALUSrcA_o(alu_src_a), .ALUSrcB_o(alu_src_b),
      .ALUControl_o(alu_control), .ImmSrc_o(imm_src), .RegWrite_o(reg_write),
      .state_o(state), .illegal_o(illegal)
   );

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({state, pc_write, ir_write, mem_write, reg_write, illegal} !== 9'b0)
         $display("FAIL reset_strobes: got %b required %b",
                  {state, pc_write, ir_write, mem_write, reg_write, illegal}, 9'b0);
      else passes++;
      checks++;
      if ({alu_src_b, result_src, alu_control} !== 7'b1010000)
         $display("FAIL reset_fetch_mux: got %b required %b",
                  {alu_src_b, result_src, alu_control}, 7'b1010000);
      else passes++;
      rst = 1'b0; #1;
      checks++;
      if ({ir_write, pc_write} !== 2'b11)
         $display("FAIL fetch_after_reset: got %b required 11", {ir_write, pc_write});
      else passes++;
   endtask

   task automatic test_lw();
      logic [3:0] st [6];
      st = '{0, 1, 2, 3, 4, 0};
      instr = 32'h00402083; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (state !== st[i]) $display("FAIL lw_state%0d: got %0d required %0d", i, state, st[i]);
         else passes++;
         checks++;
         if (reg_write !== (i == 4))
            $display("FAIL lw_regwrite%0d: got %b required %b", i, reg_write, i == 4);
         else passes++;
         if (i == 3) begin
            checks++;
            if (adr_src !== 1'b1) $display("FAIL lw_adrsrc: got %b required 1", adr_src);
            else passes++;
         end
         if (i == 4) begin
            checks++;
            if (result_src !== 2'b01) $display("FAIL lw_resultsrc: got %b required 01", result_src);
            else passes++;
         end
         if (i < 5) @(negedge clk);
      end
   endtask

   task automatic test_sw_wait();
      logic [3:0] st [7];
      logic       rdy [7];
      st  = '{0, 1, 2, 5, 5, 5, 0};
      rdy = '{1, 1, 1, 0, 0, 1, 1};
      instr = 32'h0020A223;
      for (int i = 0; i < 7; i++) begin
         mem_ready = rdy[i]; #1;
         checks++;
         if (state !== st[i]) $display("FAIL sw_state%0d: got %0d required %0d", i, state, st[i]);
         else passes++;
         checks++;
         if (mem_write !== (st[i] == 5))
            $display("FAIL sw_memwrite%0d: got %b required %b", i, mem_write, st[i] == 5);
         else passes++;
         if (st[i] == 5) begin
            checks++;
            if (adr_src !== 1'b1) $display("FAIL sw_adrsrc%0d: got %b required 1", i, adr_src);
            else passes++;
         end
         if (i == 1 || i == 2) begin
            checks++;
            if (imm_src !== 2'b01) $display("FAIL sw_immsrc%0d: got %b required 01", i, imm_src);
            else passes++;
         end
         if (i < 6) @(negedge clk);
      end
   endtask

   // Fetch stall on the add, then back-to-back sub and an addi whose imm sets bit 30.
   task automatic test_alu();
      logic [31:0] ins [3];
      logic [3:0]  ex [3];
      logic [2:0]  fn [3];
      logic [1:0]  srcb [3];
      ins  = '{32'h002081B3, 32'h402081B3, 32'h40008093};
      ex   = '{6, 6, 7};
      fn   = '{3'b000, 3'b001, 3'b000};
      srcb = '{2'b00, 2'b00, 2'b01};
      for (int k = 0; k < 3; k++) begin
         instr = ins[k];
         if (k == 0) begin
            mem_ready = 1'b0; #1;
            checks++;
            if ({state, ir_write, pc_write} !== 6'b000000)
               $display("FAIL fetch_stall: got %b required 000000", {state, ir_write, pc_write});
            else passes++;
            @(negedge clk);
            mem_ready = 1'b1;
         end
         @(negedge clk); @(negedge clk); #1;
         checks++;
         if ({state, alu_control, alu_src_a, alu_src_b} !== {ex[k], fn[k], 2'b10, srcb[k]})
            $display("FAIL alu_exec%0d: got %b required %b", k,
                     {state, alu_control, alu_src_a, alu_src_b}, {ex[k], fn[k], 2'b10, srcb[k]});
         else passes++;
         @(negedge clk); #1;
         checks++;
         if ({state, reg_write} !== 5'b10001)
            $display("FAIL alu_wb%0d: got %b required 10001", k, {state, reg_write});
         else passes++;
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      logic [31:0] ins [5];
      logic        eqv [5];
      logic        exp_pc [5];
      ins    = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h00209463, 32'h0020A463};
      eqv    = '{1, 0, 0, 1, 1};
      exp_pc = '{1, 0, 1, 0, 0};
      for (int k = 0; k < 5; k++) begin
         instr = ins[k]; eq = eqv[k];
         @(negedge clk); #1;
         checks++;
         if (imm_src !== 2'b10) $display("FAIL br_immsrc%0d: got %b required 10", k, imm_src);
         else passes++;
         @(negedge clk); #1;
         checks++;
         if ({state, pc_write, alu_control} !== {4'd9, exp_pc[k], 3'b001})
            $display("FAIL br_pcwrite%0d: got %b required %b", k,
                     {state, pc_write, alu_control}, {4'd9, exp_pc[k], 3'b001});
         else passes++;
         @(negedge clk); #1;
         checks++;
         if (state !== 4'd0) $display("FAIL br_done%0d: got %0d required 0", k, state);
         else passes++;
      end
      eq = 1'b0;
   endtask

   task automatic test_jal();
      logic [3:0] st [5];
      st = '{0, 1, 10, 8, 0};
      instr = 32'h008000EF;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (state !== st[i]) $display("FAIL jal_state%0d: got %0d required %0d", i, state, st[i]);
         else passes++;
         if (i == 2) begin
            checks++;
            if ({pc_write, imm_src, alu_src_a, alu_src_b} !== 7'b1110110)
               $display("FAIL jal_exec: got %b required 1110110",
                        {pc_write, imm_src, alu_src_a, alu_src_b});
            else passes++;
         end
         if (i == 3) begin
            checks++;
            if (reg_write !== 1'b1) $display("FAIL jal_regwrite: got %b required 1", reg_write);
            else passes++;
         end
         if (i < 4) @(negedge clk);
      end
   endtask

   task automatic test_trap();
      instr = 32'h0000007F;
      @(negedge clk); @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if ({state, illegal, pc_write, ir_write, mem_write, reg_write} !== 9'b101110000)
            $display("FAIL trap%0d: got %b required 101110000", i,
                     {state, illegal, pc_write, ir_write, mem_write, reg_write});
         else passes++;
         @(negedge clk);
      end
      rst = 1'b1; #1;
      checks++;
      if ({state, illegal} !== 5'b00000)
         $display("FAIL trap_reset: got %b required 00000", {state, illegal});
      else passes++;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset_in_memwrite();
      instr = 32'h0020A223; mem_ready = 1'b1;
      @(negedge clk); @(negedge clk); @(negedge clk);
      mem_ready = 1'b0; #1;
      checks++;
      if ({state, mem_write} !== 5'b01011)
         $display("FAIL memwrite_before_reset: got %b required 01011", {state, mem_write});
      else passes++;
      rst = 1'b1; #1;
      checks++;
      if ({state, mem_write} !== 5'b00000)
         $display("FAIL memwrite_reset_drop: got %b required 00000", {state, mem_write});
      else passes++;
      @(negedge clk); rst = 1'b0; mem_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_wait();
      test_alu();
      test_branch();
      test_jal();
      test_trap();
      test_reset_in_memwrite();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style control FSM for the multicycle RV32I datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states, driving the shared-ALU and single-memory datapath. Adds a memory-ready handshake, bne support and an illegal-opcode trap state. Sits between the instruction register / ALU flags and every datapath mux and write enable.

## Interface
- INSTR_WIDTH, 32, instruction width; only bits [31:0] are decoded.
- MEM_WAIT_EN, 1, 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready_i; 0 = mem_ready_i ignored (treated as 1).
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_i  in  INSTR_WIDTH  instruction register output.
- eq_i  in  1  ALU operands equal.
- mem_ready_i  in  1  memory access completes this cycle.
- PCWrite_o  out  1  PC register enable.
- AdrSrc_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite_o  out  1  data memory write strobe.
- IRWrite_o  out  1  instruction register / OldPC enable.
- ResultSrc_o  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA_o  out  2  00 PC, 01 OldPC, 10 rs1 data.
- ALUSrcB_o  out  2  00 rs2 data, 01 ImmExt, 10 constant 4.
- ALUControl_o  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc_o  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type.
- RegWrite_o  out  1  register file write enable.
- state_o  out  4  current state encoding (debug).
- illegal_o  out  1  high while in TRAP.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 11. Encodings 12–15 are unreachable; if entered, next state is FETCH.
- Fields opcode = instr[6:0], funct3 = [14:12], funct7b5 = [30] are registered at the DECODE edge. All later states decode from these registered fields.
- ImmSrc_o is combinational from the opcode (live instr_i in DECODE, registered fields otherwise):
  - lw, I-ALU: 00
  - sw: 01
  - branch: 10
  - jal: 11
  - anything else: 00
- Transitions:
  - FETCH→DECODE when ready, else stay in FETCH.
  - DECODE by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 (R-type) → EXECR
    - 0010011 (I-ALU) → EXECI
    - 1100011 (branch) → BRANCH
    - 1101111 (jal) → JAL
    - anything else → TRAP
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB when ready.
  - MEMWB→FETCH.
  - MEMWRITE→FETCH when ready.
  - EXECR/EXECI→ALUWB; ALUWB→FETCH.
  - BRANCH→FETCH.
  - JAL→ALUWB.
  - TRAP→TRAP until reset.
- Outputs per state (unlisted signals are 0 / 00):
  - FETCH: IRWrite=ready, PCWrite=ready, ALUSrcB=10, ALUControl add, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1 (held until ready).
  - EXECR: ALUSrcA=10, ALUSrcB=00, funct decode.
  - EXECI: ALUSrcA=10, ALUSrcB=01, funct decode.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite = (funct3==000 & eq_i) | (funct3==001 & !eq_i).
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
  - TRAP: illegal_o=1, all strobes 0.
- Funct decode (EXECR/EXECI):
  - funct3 000 → sub if opcode[5] & funct7b5, else add.
  - 010 → slt.
  - 110 → or.
  - 111 → and.
  - other funct3 → add, no trap.
- Branch funct3 other than 000/001: PCWrite=0, and the instruction completes as not-taken.

## Timing
- Registered state, combinational outputs; no output register stage.
- Latency without waits:
  - lw 5 cycles
  - sw 4 cycles
  - R-type, I-ALU and jal 4 cycles
  - branch 3 cycles
- Each low mem_ready_i cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset: rst_i high forces state FETCH immediately and clears the registered fields to 0.
  - While rst_i is high, PCWrite, IRWrite, MemWrite and RegWrite are forced 0 and illegal_o is 0.
  - Other outputs take their FETCH values.
- Reset mid-instruction (e.g. during MEMWRITE) drops MemWrite_o combinationally in the same cycle.
- First FETCH strobes may assert in the first cycle after rst_i deasserts.

## Test plan
- Reset, then lw x1,4(x0) (0x00402083) with mem_ready_i=1 → states 0,1,2,3,4,0; RegWrite_o=1 only in state 4; ResultSrc_o=01 there.
- sw (0x0020A223), mem_ready_i low for 2 cycles in MEMWRITE → MemWrite_o=1 for 3 cycles; AdrSrc_o=1; FETCH follows.
- add (0x002081B3) then sub (0x402081B3) → ALUControl_o=000 in EXECR for add, 001 for sub; ALUWB asserts RegWrite_o=1.
- beq (0x00208463) with eq_i=1 → PCWrite_o=1 in BRANCH. Repeat with eq_i=0 → PCWrite_o=0. bne (0x00209463) with eq_i=0 → PCWrite_o=1.
- jal (0x008000EF) → states 0,1,10,8; PCWrite_o=1 in JAL; RegWrite_o=1 in ALUWB.
- Opcode 0x0000007F → TRAP, illegal_o=1, all strobes 0 for 10 cycles. Assert rst_i → state_o=0 and illegal_o=0 asynchronously.
